// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcode encodings, default widths, opcode field
// position and the fetch FSM state type.
package instr_fetch_pkg;

  localparam int unsigned PC_W_DEF    = 8;
  localparam int unsigned INSTR_W_DEF = 16;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'b0000;
  localparam opcode_t OP_SUB  = 4'b0001;
  localparam opcode_t OP_AND  = 4'b0010;
  localparam opcode_t OP_OR   = 4'b0011;
  localparam opcode_t OP_LD   = 4'b0100;
  localparam opcode_t OP_ST   = 4'b0101;
  localparam opcode_t OP_BEQ  = 4'b0110;
  localparam opcode_t OP_J    = 4'b0111;
  localparam opcode_t OP_HALT = 4'b1111;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction and its fetch address.
// Supports push-while-pop so a full buffer can refill on the cycle it drains.
module fetch_skid_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [PC_W-1:0]   in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [PC_W-1:0]   out_pc_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_pc_o    = pc_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (out_ready_i) valid_d = 1'b0;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
      pc_d    = in_pc_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues 1-cycle-latency memory reads, buffers responses in
// an output register plus a skid entry, and handles redirect and HALT.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [3:0]         out_opcode,
  output logic [PC_W-1:0]    out_pc
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               rsp_q, rsp_d;
  logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
  logic               ov_q, ov_d;
  logic [INSTR_W-1:0] oi_q, oi_d;
  logic [PC_W-1:0]    opc_q, opc_d;

  logic               xfer, halt_xfer, out_free, room, issue;
  logic [1:0]         occ;
  logic               skid_push, skid_flush, skid_in_ready, skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [PC_W-1:0]    skid_pc;

  assign xfer      = ov_q && out_ready;
  assign halt_xfer = xfer && (oi_q[OPC_MSB:OPC_LSB] == OP_HALT);
  assign out_free  = !ov_q || xfer;

  // Entries held after this edge; a new read is safe only if one slot stays free for it.
  assign occ   = 2'(ov_q) + 2'(skid_valid) + 2'(rsp_q) - 2'(xfer);
  assign room  = (occ < 2'd2);
  assign issue = !reset && (state_q == FETCH) && room && !redirect && !halt_xfer;

  assign skid_push  = rsp_q && !(out_free && !skid_valid);
  assign skid_flush = redirect || halt_xfer;

  assign imem_en    = issue;
  assign imem_addr  = reset ? '0 : pc_q;
  assign out_valid  = ov_q;
  assign out_instr  = oi_q;
  assign out_opcode = oi_q[OPC_MSB:OPC_LSB];
  assign out_pc     = opc_q;

  fetch_skid_buf #(
    .DATA_W (INSTR_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (skid_flush),
    .in_valid_i  (skid_push),
    .in_ready_o  (skid_in_ready),
    .in_data_i   (imem_rdata),
    .in_pc_i     (rsp_pc_q),
    .out_valid_o (skid_valid),
    .out_ready_i (xfer),
    .out_data_o  (skid_data),
    .out_pc_o    (skid_pc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_d    = 1'b0;
    rsp_pc_d = rsp_pc_q;
    ov_d     = ov_q;
    oi_d     = oi_q;
    opc_d    = opc_q;
    if (issue) begin
      pc_d     = pc_q + PC_W'(1);
      rsp_d    = 1'b1;
      rsp_pc_d = pc_q;
    end
    if (xfer) ov_d = 1'b0;
    if (xfer && skid_valid) begin
      ov_d  = 1'b1;
      oi_d  = skid_data;
      opc_d = skid_pc;
    end else if (rsp_q && out_free && !skid_valid) begin
      ov_d  = 1'b1;
      oi_d  = imem_rdata;
      opc_d = rsp_pc_q;
    end
    if (redirect) begin
      state_d = FETCH;
      pc_d    = redirect_target;
      ov_d    = 1'b0;
      rsp_d   = 1'b0;
    end else if (halt_xfer) begin
      state_d = HALT;
      ov_d    = 1'b0;
      rsp_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      rsp_q    <= 1'b0;
      rsp_pc_q <= '0;
      ov_q     <= 1'b0;
      oi_q     <= '0;
      opc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_q    <= rsp_d;
      rsp_pc_q <= rsp_pc_d;
      ov_q     <= ov_d;
      oi_q     <= oi_d;
      opc_q    <= opc_d;
      assert (!skid_push || skid_in_ready);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of fetch segments plus hand-written
// HALT, redirect and reset sequences, scored against an expected-transfer queue.
module tb_instr_fetch;

  localparam int unsigned PW = 8;
  localparam int unsigned IW = 16;

  logic          clk = 1'b0;
  logic          reset, imem_en, redirect, out_valid, out_ready;
  logic [PW-1:0] imem_addr, redirect_target, out_pc;
  logic [IW-1:0] imem_rdata, out_instr;
  logic [3:0]    out_opcode;

  logic [IW-1:0] mem [256];

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [PW-1:0] target;
    int unsigned   count;
    logic [PW-1:0] stall_pc;
    int unsigned   stall_len;
    int unsigned   exp_cycles;
  } vec_t;
  vec_t vecs[5];

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic          prev_v = 1'b0, prev_rdy = 1'b0, prev_redir = 1'b0, prev_rst = 1'b1;
  logic [PW-1:0] prev_pc = '0;
  logic [IW-1:0] prev_instr = '0;

  instr_fetch #(.PC_W(PW), .INSTR_W(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_opcode      (out_opcode),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [IW-1:0] mem_init(input logic [PW-1:0] a);
    if (a >= 8'h80 && a <= 8'h8E) return {a[3:0], 4'h0, a};
    return {8'h00, a};
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Sample one cycle at the falling edge: hold check, then score any transfer.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (!reset && !prev_rst && prev_v && !prev_rdy && !prev_redir) begin
      chk_eq("hold_valid", 32'(out_valid), 32'd1);
      chk_eq("hold_pc", 32'(out_pc), 32'(prev_pc));
      chk_eq("hold_instr", 32'(out_instr), 32'(prev_instr));
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got transfer of pc 0x%0h, required none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk_eq("xfer_pc", 32'(out_pc), 32'(e.pc));
        chk_eq("xfer_instr", 32'(out_instr), 32'(e.instr));
        chk_eq("xfer_opcode", 32'(out_opcode), 32'(e.instr[15:12]));
      end
    end
    prev_v     = out_valid;
    prev_rdy   = out_ready;
    prev_redir = redirect;
    prev_rst   = reset;
    prev_pc    = out_pc;
    prev_instr = out_instr;
  endtask

  // Start fetching at target (via reset release or redirect) and drain count transfers.
  task automatic run_seg(input bit by_reset, input bit rdy_live, input logic [PW-1:0] target,
                         input int unsigned count, input logic [PW-1:0] stall_pc,
                         input int unsigned stall_len, input int unsigned exp_cycles);
    logic [PW-1:0] a;
    int unsigned   cyc, stall_cnt;
    bit            stall_done;
    for (int unsigned k = 0; k < count; k++) begin
      a = target + PW'(k);
      exp_q.push_back('{pc: a, instr: mem[a]});
    end
    if (by_reset) begin
      reset = 1'b0;
    end else begin
      out_ready       = rdy_live;
      redirect        = 1'b1;
      redirect_target = target;
      sample();
      @(posedge clk); #1;
      redirect = 1'b0;
    end
    out_ready = 1'b1;
    sample();
    chk_eq("c0_imem_en", 32'(imem_en), 32'd1);
    chk_eq("c0_imem_addr", 32'(imem_addr), 32'(target));
    chk_eq("c0_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    sample();
    chk_eq("c1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    cyc = 0;
    stall_cnt = 0;
    stall_done = 1'b0;
    while (exp_q.size() != 0 && cyc < 100) begin
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (!stall_done && stall_len > 0 && out_valid && out_pc == stall_pc) begin
        out_ready  = 1'b0;
        stall_cnt  = stall_len - 1;
        stall_done = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      sample();
      if (cyc == 0) chk_eq("first_pc", 32'(out_pc), 32'(target));
      chk_eq("no_gap_valid", 32'(out_valid), 32'd1);
      cyc++;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
    chk_eq("seg_cycles", cyc, exp_cycles);
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mem_init(PW'(i));
    vecs[0] = '{8'h10, 8,  8'h00, 0, 8};
    vecs[1] = '{8'h01, 6,  8'h03, 5, 11};
    vecs[2] = '{8'hFE, 4,  8'h00, 0, 4};
    vecs[3] = '{8'h80, 15, 8'h84, 2, 17};
    vecs[4] = '{8'h20, 3,  8'h20, 1, 4};

    reset = 1'b1;
    redirect = 1'b1;
    redirect_target = 8'h55;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      sample();
    end
    chk_eq("rst_imem_en", 32'(imem_en), 32'd0);
    chk_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_out_instr", 32'(out_instr), 32'd0);
    chk_eq("rst_out_opcode", 32'(out_opcode), 32'd0);
    chk_eq("rst_out_pc", 32'(out_pc), 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    run_seg(1'b1, 1'b1, 8'h00, 10, 8'h00, 0, 10);

    for (int v = 0; v < 5; v++)
      run_seg(1'b0, 1'b0, vecs[v].target, vecs[v].count, vecs[v].stall_pc,
              vecs[v].stall_len, vecs[v].exp_cycles);

    // HALT transfers once, then fetch stays idle until redirected.
    mem[5] = 16'hF000;
    run_seg(1'b0, 1'b0, 8'h02, 4, 8'h00, 0, 4);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample();
      chk_eq("halt_out_valid", 32'(out_valid), 32'd0);
      chk_eq("halt_imem_en", 32'(imem_en), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    run_seg(1'b0, 1'b0, 8'h10, 3, 8'h00, 0, 3);

    // Redirect in the same cycle the HALT instruction transfers.
    run_seg(1'b0, 1'b0, 8'h03, 2, 8'h00, 0, 2);
    chk_eq("halt_pending_valid", 32'(out_valid), 32'd1);
    chk_eq("halt_pending_pc", 32'(out_pc), 32'h05);
    exp_q.push_back('{pc: 8'h05, instr: 16'hF000});
    run_seg(1'b0, 1'b1, 8'h30, 2, 8'h00, 0, 2);
    mem[5] = mem_init(8'h05);

    // Reset while stalled with a valid output.
    reset = 1'b1;
    sample();
    chk_eq("midrst_imem_en", 32'(imem_en), 32'd0);
    chk_eq("midrst_imem_addr", 32'(imem_addr), 32'd0);
    @(posedge clk); #1;
    sample();
    chk_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("midrst_out_instr", 32'(out_instr), 32'd0);
    chk_eq("midrst_out_opcode", 32'(out_opcode), 32'd0);
    chk_eq("midrst_out_pc", 32'(out_pc), 32'd0);
    @(posedge clk); #1;

    // pc 7 on the output and pc 8 in flight when the redirect hits.
    run_seg(1'b1, 1'b1, 8'h00, 7, 8'h00, 0, 7);
    chk_eq("pre_redirect_valid", 32'(out_valid), 32'd1);
    chk_eq("pre_redirect_pc", 32'(out_pc), 32'h07);
    exp_q.push_back('{pc: 8'h07, instr: mem[7]});
    run_seg(1'b0, 1'b1, 8'h40, 3, 8'h00, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
